// File: rtl/cache_victim_ctrl_16way_if.sv
// Bus between a 16-way cache datapath/requester and its miss/victim controller.
// The requester side uses master; the controller uses slave.
interface cache_victim_ctrl_16way_if;
  logic        hit_req;
  logic [3:0]  hit_way;
  logic        miss_req;
  logic [15:0] valid_bits;
  logic [15:0] dirty_bits;
  logic [3:0]  lru_way;
  logic        mem_resp;
  logic        lru_load;
  logic [3:0]  lru_hit;
  logic        pmem_write;
  logic        pmem_read;
  logic [3:0]  victim_way;
  logic [15:0] way_load;
  logic        miss_done;
  logic        busy;

  modport master (
    output hit_req, hit_way, miss_req, valid_bits, dirty_bits, lru_way, mem_resp,
    input  lru_load, lru_hit, pmem_write, pmem_read, victim_way, way_load, miss_done, busy
  );

  modport slave (
    input  hit_req, hit_way, miss_req, valid_bits, dirty_bits, lru_way, mem_resp,
    output lru_load, lru_hit, pmem_write, pmem_read, victim_way, way_load, miss_done, busy
  );
endinterface

// File: rtl/cache_victim_ctrl_16way.sv
// Miss controller for a 16-way set: picks a victim (invalid way first, else PLRU),
// writes it back if dirty, fills it, installs it and promotes it in the PLRU tracker.
module cache_victim_ctrl_16way (
  input  logic                      clk,
  input  logic                      reset,
  cache_victim_ctrl_16way_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    WRITEBACK,
    FILL,
    INSTALL,
    DONE
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [3:0]  r_victim_way;
  logic        r_lru_load;
  logic [3:0]  r_lru_hit;

  logic [3:0]  w_chosen_way;
  logic        w_chosen_dirty;
  logic        w_pmem_write;
  logic        w_pmem_read;
  logic [15:0] w_way_load;
  logic        w_miss_done;
  logic        w_busy;

  // Descending scan so the lowest-index invalid way wins; PLRU only when the set is full.
  always_comb begin
    w_chosen_way = bus.lru_way;
    for (int i = 15; i >= 0; i--) begin
      if (!bus.valid_bits[i]) begin
        w_chosen_way = 4'(i);
      end
    end
    w_chosen_dirty = bus.valid_bits[w_chosen_way] & bus.dirty_bits[w_chosen_way];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_pmem_write = 1'b0;
    w_pmem_read  = 1'b0;
    w_way_load   = 16'h0000;
    w_miss_done  = 1'b0;
    w_busy       = 1'b1;
    case (r_state)
      IDLE: begin
        w_busy = 1'b0;
        if (bus.miss_req) begin
          w_next_state = SELECT;
        end
      end
      SELECT: begin
        w_next_state = w_chosen_dirty ? WRITEBACK : FILL;
      end
      WRITEBACK: begin
        w_pmem_write = 1'b1;
        if (bus.mem_resp) begin
          w_next_state = FILL;
        end
      end
      FILL: begin
        w_pmem_read = 1'b1;
        if (bus.mem_resp) begin
          w_next_state = INSTALL;
        end
      end
      INSTALL: begin
        w_way_load   = 16'h0001 << r_victim_way;
        w_next_state = DONE;
      end
      DONE: begin
        w_miss_done  = 1'b1;
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // The PLRU update is registered so the tracker sees a full-period stable strobe;
  // a miss promotes its victim in the DONE cycle, which is loaded while in INSTALL.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_victim_way <= 4'd0;
      r_lru_load   <= 1'b0;
      r_lru_hit    <= 4'd0;
    end else begin
      r_lru_load <= 1'b0;
      if (r_state == SELECT) begin
        r_victim_way <= w_chosen_way;
      end
      if (r_state == IDLE && bus.hit_req && !bus.miss_req) begin
        r_lru_load <= 1'b1;
        r_lru_hit  <= bus.hit_way;
      end else if (r_state == INSTALL) begin
        r_lru_load <= 1'b1;
        r_lru_hit  <= r_victim_way;
      end
    end
  end

  assign bus.pmem_write = w_pmem_write;
  assign bus.pmem_read  = w_pmem_read;
  assign bus.way_load   = w_way_load;
  assign bus.miss_done  = w_miss_done;
  assign bus.busy       = w_busy;
  assign bus.victim_way = r_victim_way;
  assign bus.lru_load   = r_lru_load;
  assign bus.lru_hit    = r_lru_hit;

endmodule

// File: tb/tb_cache_victim_ctrl_16way.sv
// Self-checking bench for cache_victim_ctrl_16way: directed scenarios plus random misses
// compared against a transaction-level model of victim choice, latency and strobes.
module tb_cache_victim_ctrl_16way;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cache_victim_ctrl_16way_if bus ();

  cache_victim_ctrl_16way dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int fails  = 0;

  int          obsLat;
  int          obsWb;
  int          obsRd;
  int          obsBoth;
  int          obsLruLoads;
  int          obsWayLoadCycle;
  logic [15:0] obsWayLoad;
  logic [3:0]  obsDoneLruHit;
  logic [3:0]  obsVictim;
  logic [2:0]  obsAfterDone;

  function automatic int modelVictim(input logic [15:0] v, input logic [3:0] lru);
    for (int i = 0; i < 16; i++) begin
      if (((v >> i) & 16'd1) == 16'd0) return i;
    end
    return int'(lru);
  endfunction

  function automatic int modelWbCycles(input logic [15:0] v, input logic [15:0] d,
                                       input logic [3:0] lru, input int wbLat);
    int w;
    w = modelVictim(v, lru);
    return (v[w] && d[w]) ? wbLat : 0;
  endfunction

  // Drives one miss, answering each memory request after the requested number of cycles.
  task automatic applyStimulus(input logic [15:0] v, input logic [15:0] d, input logic [3:0] lru,
                               input int wbLat, input int fillLat, input bit noisy,
                               input bit initHit, input logic [3:0] initHitWay);
    int c;
    int wbCnt;
    int rdCnt;
    c = 0; wbCnt = 0; rdCnt = 0;
    obsLat = -1; obsBoth = 0; obsLruLoads = 0; obsWayLoad = 16'h0; obsWayLoadCycle = -1;
    obsDoneLruHit = 4'hx;
    bus.valid_bits = v; bus.dirty_bits = d; bus.lru_way = lru;
    bus.miss_req = 1'b1; bus.mem_resp = 1'b0;
    bus.hit_req = initHit; bus.hit_way = initHitWay;
    while (c < 80 && obsLat < 0) begin
      @(posedge clk); #1;
      c++;
      bus.hit_req = 1'b0;
      if (noisy) begin
        bus.hit_req = 1'($urandom_range(0, 1));
        bus.hit_way = 4'($urandom);
        if (c >= 2) begin
          bus.valid_bits = 16'($urandom);
          bus.dirty_bits = 16'($urandom);
          bus.lru_way    = 4'($urandom);
        end
      end
      if (bus.pmem_write && bus.pmem_read) obsBoth++;
      if (bus.pmem_write) wbCnt++;
      if (bus.pmem_read) rdCnt++;
      if (bus.way_load != 16'h0) begin
        obsWayLoad = bus.way_load;
        obsWayLoadCycle = c;
      end
      if (bus.lru_load) obsLruLoads++;
      bus.mem_resp = (bus.pmem_write && wbCnt == wbLat) || (bus.pmem_read && rdCnt == fillLat);
      if (bus.miss_done) begin
        obsLat = c;
        obsDoneLruHit = bus.lru_load ? bus.lru_hit : 4'hx;
        bus.miss_req = 1'b0; bus.hit_req = 1'b0; bus.mem_resp = 1'b0;
      end
    end
    bus.miss_req = 1'b0; bus.hit_req = 1'b0; bus.mem_resp = 1'b0;
    obsWb = wbCnt; obsRd = rdCnt;
    @(posedge clk); #1;
    obsAfterDone = {bus.busy, bus.miss_done, bus.lru_load};
    obsVictim = bus.victim_way;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.miss_req = 1'b1; bus.hit_req = 1'b1; bus.hit_way = 4'd3; bus.mem_resp = 1'b1;
    bus.valid_bits = 16'h0; bus.dirty_bits = 16'hFFFF; bus.lru_way = 4'd5;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy got %b want 0", bus.busy); end
    checks++; if (bus.lru_load !== 1'b0) begin fails++; $display("[TB] FAIL reset_lru_load got %b want 0", bus.lru_load); end
    checks++; if (bus.lru_hit !== 4'd0) begin fails++; $display("[TB] FAIL reset_lru_hit got %0d want 0", bus.lru_hit); end
    checks++; if (bus.victim_way !== 4'd0) begin fails++; $display("[TB] FAIL reset_victim got %0d want 0", bus.victim_way); end
    checks++; if ({bus.pmem_read, bus.pmem_write} !== 2'b00) begin fails++; $display("[TB] FAIL reset_pmem got %b want 00", {bus.pmem_read, bus.pmem_write}); end
    checks++; if (bus.way_load !== 16'h0) begin fails++; $display("[TB] FAIL reset_way_load got %h want 0000", bus.way_load); end
    checks++; if (bus.miss_done !== 1'b0) begin fails++; $display("[TB] FAIL reset_miss_done got %b want 0", bus.miss_done); end
    reset = 1'b0;
    bus.miss_req = 1'b0; bus.hit_req = 1'b0; bus.mem_resp = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus.busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_release_busy got %b want 0", bus.busy); end
  endtask

  task automatic test_hit_promotion();
    logic [3:0] prevWay;
    bus.mem_resp = 1'b1;
    bus.hit_req = 1'b1; bus.hit_way = 4'd9;
    @(posedge clk); #1;
    bus.hit_req = 1'b0;
    checks++; if (bus.lru_load !== 1'b1) begin fails++; $display("[TB] FAIL hit_lru_load got %b want 1", bus.lru_load); end
    checks++; if (bus.lru_hit !== 4'd9) begin fails++; $display("[TB] FAIL hit_lru_hit got %0d want 9", bus.lru_hit); end
    checks++; if (bus.busy !== 1'b0) begin fails++; $display("[TB] FAIL hit_busy got %b want 0", bus.busy); end
    @(posedge clk); #1;
    checks++; if (bus.lru_load !== 1'b0) begin fails++; $display("[TB] FAIL hit_single_pulse got %b want 0", bus.lru_load); end
    prevWay = 4'($urandom);
    bus.hit_req = 1'b1; bus.hit_way = prevWay;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.lru_load !== 1'b1 || bus.lru_hit !== prevWay) begin
        fails++;
        $display("[TB] FAIL hit_consecutive got load=%b way=%0d want load=1 way=%0d", bus.lru_load, bus.lru_hit, prevWay);
      end
      prevWay = 4'($urandom);
      bus.hit_way = prevWay;
    end
    bus.hit_req = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({bus.busy, bus.pmem_read, bus.pmem_write} !== 3'b000) begin
      fails++;
      $display("[TB] FAIL hit_mem_resp_ignored got %b want 000", {bus.busy, bus.pmem_read, bus.pmem_write});
    end
    bus.mem_resp = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_invalid_way();
    applyStimulus(16'hFFEB, 16'($urandom), 4'd7, 2, 2, 1'b0, 1'b0, 4'd0);
    checks++; if (obsVictim !== 4'd2) begin fails++; $display("[TB] FAIL invalid_victim got %0d want 2", obsVictim); end
    checks++; if (obsWb !== 0) begin fails++; $display("[TB] FAIL invalid_no_write got %0d want 0", obsWb); end
    checks++; if (obsRd !== 2) begin fails++; $display("[TB] FAIL invalid_read_cycles got %0d want 2", obsRd); end
    checks++; if (obsWayLoad !== 16'h0004) begin fails++; $display("[TB] FAIL invalid_way_load got %h want 0004", obsWayLoad); end
    checks++; if (obsDoneLruHit !== 4'd2) begin fails++; $display("[TB] FAIL invalid_lru_hit got %0d want 2", obsDoneLruHit); end
    checks++; if (obsLat !== 5) begin fails++; $display("[TB] FAIL invalid_latency got %0d want 5", obsLat); end
  endtask

  task automatic test_dirty_plru();
    applyStimulus(16'hFFFF, 16'h8000, 4'd15, 3, 1, 1'b0, 1'b0, 4'd0);
    checks++; if (obsWb !== 3) begin fails++; $display("[TB] FAIL dirty_write_cycles got %0d want 3", obsWb); end
    checks++; if (obsRd !== 1) begin fails++; $display("[TB] FAIL dirty_read_cycles got %0d want 1", obsRd); end
    checks++; if (obsWayLoad !== 16'h8000) begin fails++; $display("[TB] FAIL dirty_way_load got %h want 8000", obsWayLoad); end
    checks++; if (obsLat !== 7) begin fails++; $display("[TB] FAIL dirty_latency got %0d want 7", obsLat); end
    checks++; if (obsBoth !== 0) begin fails++; $display("[TB] FAIL dirty_both_pmem got %0d want 0", obsBoth); end
  endtask

  task automatic test_clean_plru();
    applyStimulus(16'hFFFF, 16'h0000, 4'd5, 1, 1, 1'b0, 1'b0, 4'd0);
    checks++; if (obsLat !== 4) begin fails++; $display("[TB] FAIL clean_latency got %0d want 4", obsLat); end
    checks++; if (obsWb !== 0) begin fails++; $display("[TB] FAIL clean_no_write got %0d want 0", obsWb); end
    checks++; if (obsVictim !== 4'd5) begin fails++; $display("[TB] FAIL clean_victim got %0d want 5", obsVictim); end
    checks++; if (obsAfterDone !== 3'b000) begin fails++; $display("[TB] FAIL clean_after_done got %b want 000", obsAfterDone); end
  endtask

  task automatic test_simultaneous();
    applyStimulus(16'hFFFF, 16'h0000, 4'd6, 1, 1, 1'b0, 1'b1, 4'd3);
    checks++; if (obsLruLoads !== 1) begin fails++; $display("[TB] FAIL simul_lru_loads got %0d want 1", obsLruLoads); end
    checks++; if (obsDoneLruHit !== 4'd6) begin fails++; $display("[TB] FAIL simul_lru_hit got %0d want 6", obsDoneLruHit); end
    checks++; if (obsLat !== 4) begin fails++; $display("[TB] FAIL simul_latency got %0d want 4", obsLat); end
  endtask

  task automatic test_random_misses();
    logic [15:0] v;
    logic [15:0] d;
    logic [3:0]  lru;
    int wbLat;
    int fillLat;
    int expV;
    int expWb;
    for (int n = 0; n < 25; n++) begin
      v = ($urandom_range(0, 1) == 1) ? 16'hFFFF : (16'hFFFF & ~(16'd1 << $urandom_range(0, 15)) & 16'($urandom | $urandom));
      d = 16'($urandom);
      lru = 4'($urandom);
      wbLat = $urandom_range(1, 4);
      fillLat = $urandom_range(1, 4);
      expV = modelVictim(v, lru);
      expWb = modelWbCycles(v, d, lru, wbLat);
      applyStimulus(v, d, lru, wbLat, fillLat, 1'b1, 1'b0, 4'd0);
      checks++;
      if (obsLat !== 3 + expWb + fillLat || obsVictim !== 4'(expV) || obsWb !== expWb || obsRd !== fillLat) begin
        fails++;
        $display("[TB] FAIL rand_miss v=%h d=%h lru=%0d got lat=%0d vic=%0d wb=%0d rd=%0d want lat=%0d vic=%0d wb=%0d rd=%0d",
                 v, d, lru, obsLat, obsVictim, obsWb, obsRd, 3 + expWb + fillLat, expV, expWb, fillLat);
      end
      checks++;
      if (obsWayLoad !== (16'd1 << expV) || obsWayLoadCycle !== obsLat - 1 || obsDoneLruHit !== 4'(expV)
          || obsLruLoads !== 1 || obsBoth !== 0 || obsAfterDone !== 3'b000) begin
        fails++;
        $display("[TB] FAIL rand_strobes got wl=%h@%0d lru=%0d loads=%0d both=%0d after=%b want wl=%h@%0d lru=%0d loads=1 both=0 after=000",
                 obsWayLoad, obsWayLoadCycle, obsDoneLruHit, obsLruLoads, obsBoth, obsAfterDone,
                 16'd1 << expV, obsLat - 1, expV);
      end
    end
  endtask

  task automatic test_reset_mid();
    int waitCnt;
    bit quiet;
    for (int pass = 0; pass < 2; pass++) begin
      bus.valid_bits = 16'hFFFF; bus.lru_way = 4'd5;
      bus.dirty_bits = (pass == 0) ? 16'h0000 : 16'h0020;
      bus.miss_req = 1'b1; bus.mem_resp = 1'b0;
      waitCnt = 0;
      do begin
        @(posedge clk); #1;
        waitCnt++;
      end while (!(pass == 0 ? bus.pmem_read : bus.pmem_write) && waitCnt < 10);
      checks++;
      if ((pass == 0 ? bus.pmem_read : bus.pmem_write) !== 1'b1) begin
        fails++;
        $display("[TB] FAIL midreset_reach_state pass=%0d got 0 want 1", pass);
      end
      reset = 1'b1; bus.mem_resp = 1'b1; bus.hit_req = 1'b1; bus.hit_way = 4'd3;
      @(posedge clk); #1;
      checks++;
      if ({bus.pmem_read, bus.pmem_write, bus.busy, bus.lru_load} !== 4'b0000 || bus.victim_way !== 4'd0) begin
        fails++;
        $display("[TB] FAIL midreset_outputs pass=%0d got rd/wr/busy/load=%b vic=%0d want 0000 vic=0",
                 pass, {bus.pmem_read, bus.pmem_write, bus.busy, bus.lru_load}, bus.victim_way);
      end
      reset = 1'b0; bus.miss_req = 1'b0; bus.hit_req = 1'b0; bus.mem_resp = 1'b1;
      quiet = 1'b1;
      for (int k = 0; k < 4; k++) begin
        @(posedge clk); #1;
        bus.mem_resp = 1'b0;
        if (bus.busy || bus.pmem_read || bus.pmem_write || bus.miss_done || bus.lru_load || bus.way_load != 16'h0)
          quiet = 1'b0;
      end
      checks++;
      if (quiet !== 1'b1) begin
        fails++;
        $display("[TB] FAIL midreset_quiet pass=%0d got activity=1 want 0", pass);
      end
    end
  endtask

  initial begin
    bus.hit_req = 1'b0; bus.hit_way = 4'd0; bus.miss_req = 1'b0; bus.mem_resp = 1'b0;
    bus.valid_bits = 16'hFFFF; bus.dirty_bits = 16'h0; bus.lru_way = 4'd0;
    reset = 1'b1;
    test_reset();
    test_hit_promotion();
    test_invalid_way();
    test_dirty_plru();
    test_clean_plru();
    test_simultaneous();
    test_random_misses();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/cache_victim_ctrl_16way.md
CACHE_VICTIM_CTRL_16WAY -- requirements
Module: cache_victim_ctrl_16way

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk (rising edge) and reset.
REQ-002 The block SHALL have these ports (name  direction  width  meaning):
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous active-high reset.
- hit_req  in  1  the current access hit; sampled in IDLE only.
- hit_way  in  4  way index of the hit; valid when hit_req=1.
- miss_req  in  1  the current access missed; held high by the requester until miss_done.
- valid_bits  in  16  valid bit per way of the addressed set.
- dirty_bits  in  16  dirty bit per way of the addressed set.
- lru_way  in  4  pseudo-LRU victim index from the 16-way PLRU tracker.
- mem_resp  in  1  physical-memory completion for the current read or write.
- lru_load  out  1  registered update strobe to the PLRU tracker.
- lru_hit  out  4  registered way index to promote in the PLRU tracker.
- pmem_write  out  1  writeback request; held until mem_resp.
- pmem_read  out  1  fill request; held until mem_resp.
- victim_way  out  4  registered selected victim index; drives the writeback/fill way mux.
- way_load  out  16  one-hot tag/data/valid load enable for the victim way.
- miss_done  out  1  one-cycle pulse when the miss is complete.
- busy  out  1  high in every state except IDLE.

Function
REQ-003 The FSM SHALL have exactly six states: IDLE, SELECT, WRITEBACK, FILL, INSTALL, DONE.
REQ-004 In IDLE, miss_req=1 SHALL cause a transition to SELECT; miss_req has priority over hit_req, and a hit_req in the same cycle SHALL be ignored.
REQ-005 In IDLE, hit_req=1 with miss_req=0 SHALL produce lru_load=1 and lru_hit=hit_way in the next cycle for exactly one cycle; consecutive hit cycles SHALL produce consecutive pulses.
REQ-006 lru_load and lru_hit SHALL be registered and stable for a full clock period, so the PLRU tracker samples them on its falling edge.
REQ-007 SELECT SHALL last one cycle and register victim_way as follows:
- if valid_bits != 16'hFFFF: the lowest-index way with valid_bits[i]=0;
- otherwise: lru_way.
REQ-008 SELECT SHALL transition to WRITEBACK if the chosen way has valid_bits=1 and dirty_bits=1; otherwise it SHALL transition to FILL.
REQ-009 In WRITEBACK, pmem_write SHALL be 1 every cycle until mem_resp=1, and the FSM SHALL then transition to FILL; pmem_write SHALL be 0 in FILL.
REQ-010 In FILL, pmem_read SHALL be 1 every cycle until mem_resp=1, and the FSM SHALL then transition to INSTALL.
REQ-011 INSTALL SHALL last one cycle, with way_load = 16'b1 << victim_way.
REQ-012 In the cycle after INSTALL (DONE), lru_load=1 and lru_hit=victim_way SHALL be asserted.
REQ-013 DONE SHALL last one cycle, with miss_done=1, and SHALL transition to IDLE.
REQ-014 way_load SHALL be 0 outside INSTALL, and miss_done SHALL be 0 outside DONE.
REQ-015 pmem_read and pmem_write SHALL never both be 1.
REQ-016 mem_resp SHALL be ignored outside WRITEBACK and FILL.
REQ-017 hit_req SHALL be ignored in all non-IDLE states; no lru_load is generated from it.
REQ-018 victim_way SHALL change only in SELECT and SHALL hold its value after DONE until the next SELECT.
REQ-019 valid_bits, dirty_bits and lru_way SHALL be sampled only in SELECT.
REQ-020 Minimum miss latency SHALL be 4 cycles for a clean victim with mem_resp in the first FILL cycle (miss_req in IDLE to miss_done), measured from the IDLE cycle in which miss_req is sampled to the cycle in which miss_done is high.
REQ-021 A dirty victim SHALL add the WRITEBACK cycles to the miss latency.

Reset
REQ-022 With reset=1 at a rising edge, the state SHALL become IDLE and all outputs SHALL be 0, including victim_way=4'd0 and lru_hit=4'd0.
REQ-023 Reset SHALL take effect from any state, including mid-WRITEBACK and mid-FILL.
REQ-024 Reset SHALL override miss_req, hit_req and mem_resp in the same cycle.

Verification
REQ-025 Hit promotion: IDLE, hit_req=1, hit_way=4'd9 for one cycle -> one cycle later lru_load=1, lru_hit=4'd9; busy stays 0.
REQ-026 Invalid-way preference: valid_bits=16'hFFEB, lru_way=4'd7, miss_req=1 -> victim_way=4'd2; no pmem_write; pmem_read until mem_resp; way_load=16'h0004; lru_hit=4'd2; miss_done pulse.
REQ-027 Dirty PLRU victim: valid_bits=16'hFFFF, dirty_bits=16'h8000, lru_way=4'd15, mem_resp 3 cycles after entering WRITEBACK -> pmem_write for exactly 3 cycles, then FILL, then way_load=16'h8000.
REQ-028 Clean PLRU victim: valid_bits=16'hFFFF, dirty_bits=16'h0000, lru_way=4'd5, mem_resp in the first FILL cycle -> miss_done 4 cycles after miss_req is sampled; pmem_write is never asserted.
REQ-029 Simultaneous request: hit_req=1 with hit_way=4'd3 and miss_req=1 in the same IDLE cycle -> SELECT is entered; no lru_load with lru_hit=4'd3 is generated.
REQ-030 Reset mid-operation: reset=1 during FILL with pmem_read=1 -> next cycle state=IDLE, pmem_read=0, busy=0; a later mem_resp pulse causes no output activity.
